cpu_axi_bridge: RTL and testbench

Converts the CPU's two sram-like request ports (instruction fetch, data load/store) into a single AXI4 master for the SoC interconnect. It sits directly downstream of mycpu_top's memory interfaces, replacing the direct inst/data SRAM hookup. It arbitrates between the two ports, allows at most one outstanding read and one outstanding write, and returns each response to the port that issued the request.

---
 rtl/cpu_axi_bridge_pkg.sv | 19 +
 rtl/axi_wr_channel.sv | 80 ++++++++
 rtl/cpu_axi_bridge.sv | 150 +++++++++++++++
 tb/tb_cpu_axi_bridge.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_axi_bridge_pkg.sv
// Shared constants, FSM encodings and helpers for the sram-like to AXI4 bridge.
// Pure definitions; no timing or flow control of its own.
package cpu_axi_bridge_pkg;

  localparam logic [3:0] ARID_INST      = 4'd0;
  localparam logic [3:0] ARID_DATA      = 4'd1;
  localparam logic [3:0] AWID           = 4'd1;
  localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;

  typedef enum logic [1:0] {R_IDLE, R_AR, R_R} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_AWW, W_B} wr_state_t;

  function automatic logic [2:0] axi_size(input logic [1:0] sram_size);
    return {1'b0, sram_size};
  endfunction

endpackage

// File: rtl/axi_wr_channel.sv
// Single-outstanding AXI write: AW and W raised together on start, each dropped on its own ready.
// B is taken one cycle after both complete; idle stays low until the bvalid handshake.
module axi_wr_channel
  import cpu_axi_bridge_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [1:0]            req_size,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [DATA_W/8-1:0]   req_wstrb,
  output logic                  idle,
  output logic [ADDR_W-1:0]     awaddr,
  output logic [2:0]            awsize,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [DATA_W-1:0]     wdata,
  output logic [DATA_W/8-1:0]   wstrb,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic                  bvalid,
  output logic                  bready
);

  wr_state_t state;
  logic      aw_done;
  logic      w_done;

  // A channel counts as done once its valid has dropped or is handshaking now.
  assign aw_done = ~awvalid | awready;
  assign w_done  = ~wvalid | wready;
  assign idle    = (state == W_IDLE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= W_IDLE;
      awaddr  <= '0;
      awsize  <= '0;
      awvalid <= 1'b0;
      wdata   <= '0;
      wstrb   <= '0;
      wvalid  <= 1'b0;
      bready  <= 1'b0;
    end else begin
      case (state)
        W_IDLE: begin
          if (start) begin
            awaddr  <= req_addr;
            awsize  <= axi_size(req_size);
            wdata   <= req_wdata;
            wstrb   <= req_wstrb;
            awvalid <= 1'b1;
            wvalid  <= 1'b1;
            state   <= W_AWW;
          end
        end
        W_AWW: begin
          if (awready) awvalid <= 1'b0;
          if (wready)  wvalid  <= 1'b0;
          if (aw_done && w_done) begin
            bready <= 1'b1;
            state  <= W_B;
          end
        end
        W_B: begin
          if (bvalid) begin
            bready <= 1'b0;
            state  <= W_IDLE;
          end
        end
        default: state <= W_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/cpu_axi_bridge.sv
// Bridges CPU inst/data sram-like ports onto one AXI4 master, one read and one write in flight at most.
// Accept is combinational; best-case read data_ok lands in the third cycle counting the accept cycle.
module cpu_axi_bridge
  import cpu_axi_bridge_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  inst_req,
  output logic                  inst_addr_ok,
  input  logic [ADDR_W-1:0]     inst_addr,
  output logic                  inst_data_ok,
  output logic [DATA_W-1:0]     inst_rdata,
  input  logic                  data_req,
  input  logic                  data_wr,
  input  logic [1:0]            data_size,
  input  logic [ADDR_W-1:0]     data_addr,
  input  logic [DATA_W-1:0]     data_wdata,
  input  logic [DATA_W/8-1:0]   data_wstrb,
  output logic                  data_addr_ok,
  output logic                  data_data_ok,
  output logic [DATA_W-1:0]     data_rdata,
  output logic [3:0]            arid,
  output logic [ADDR_W-1:0]     araddr,
  output logic [2:0]            arsize,
  output logic [7:0]            arlen,
  output logic [1:0]            arburst,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [3:0]            rid,
  input  logic [DATA_W-1:0]     rdata,
  input  logic                  rvalid,
  output logic                  rready,
  output logic [3:0]            awid,
  output logic [ADDR_W-1:0]     awaddr,
  output logic [2:0]            awsize,
  output logic [7:0]            awlen,
  output logic [1:0]            awburst,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [DATA_W-1:0]     wdata,
  output logic [DATA_W/8-1:0]   wstrb,
  output logic                  wlast,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic                  bvalid,
  output logic                  bready
);

  rd_state_t r_state;
  logic      rd_idle;
  logic      wr_idle;
  logic      data_rd_acc;
  logic      data_wr_acc;
  logic      inst_acc;
  logic      rd_fire;

  // Both FSMs must be idle for any accept, which gives read-after-write ordering
  // and keeps reads and writes from being accepted together. Data has priority.
  assign rd_idle     = (r_state == R_IDLE);
  assign data_rd_acc = resetn & data_req & ~data_wr & rd_idle & wr_idle;
  assign data_wr_acc = resetn & data_req &  data_wr & rd_idle & wr_idle;
  assign inst_acc    = resetn & inst_req & ~data_req & rd_idle & wr_idle;

  assign inst_addr_ok = inst_acc;
  assign data_addr_ok = data_rd_acc | data_wr_acc;

  assign rd_fire      = rvalid & rready;
  assign inst_data_ok = rd_fire & (rid == ARID_INST);
  assign data_data_ok = (rd_fire & (rid == ARID_DATA)) | (bvalid & bready);
  assign inst_rdata   = rdata;
  assign data_rdata   = rdata;

  assign arlen   = AXI_LEN_SINGLE;
  assign arburst = AXI_BURST_INCR;
  assign awid    = AWID;
  assign awlen   = AXI_LEN_SINGLE;
  assign awburst = AXI_BURST_INCR;
  assign wlast   = 1'b1;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= R_IDLE;
      arid    <= '0;
      araddr  <= '0;
      arsize  <= '0;
      arvalid <= 1'b0;
      rready  <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (data_rd_acc) begin
            arid    <= ARID_DATA;
            araddr  <= data_addr;
            arsize  <= axi_size(data_size);
            arvalid <= 1'b1;
            r_state <= R_AR;
          end else if (inst_acc) begin
            arid    <= ARID_INST;
            araddr  <= inst_addr;
            arsize  <= AXI_SIZE_WORD;
            arvalid <= 1'b1;
            r_state <= R_AR;
          end
        end
        R_AR: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            r_state <= R_R;
          end
        end
        R_R: begin
          if (rvalid) begin
            rready  <= 1'b0;
            r_state <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  axi_wr_channel #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_wr (
    .clk       (clk),
    .resetn    (resetn),
    .start     (data_wr_acc),
    .req_addr  (data_addr),
    .req_size  (data_size),
    .req_wdata (data_wdata),
    .req_wstrb (data_wstrb),
    .idle      (wr_idle),
    .awaddr    (awaddr),
    .awsize    (awsize),
    .awvalid   (awvalid),
    .awready   (awready),
    .wdata     (wdata),
    .wstrb     (wstrb),
    .wvalid    (wvalid),
    .wready    (wready),
    .bvalid    (bvalid),
    .bready    (bready)
  );

endmodule

// File: tb/tb_cpu_axi_bridge.sv
// Directed bench for cpu_axi_bridge: the bench plays the AXI slave cycle by cycle.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_cpu_axi_bridge;

  logic        clk;
  logic        resetn;
  logic        inst_req, inst_addr_ok, inst_data_ok;
  logic [31:0] inst_addr, inst_rdata;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic [3:0]  data_wstrb;
  logic [3:0]  arid, rid, awid;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic [2:0]  arsize, awsize;
  logic [7:0]  arlen, awlen;
  logic [1:0]  arburst, awburst;
  logic        arvalid, arready, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [3:0]  wstrb;

  int vectors = 0;
  int miscompares = 0;

  cpu_axi_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr_ok(inst_addr_ok), .inst_addr(inst_addr),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_wstrb(data_wstrb),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .arid(arid), .araddr(araddr), .arsize(arsize), .arlen(arlen), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awsize(awsize), .awlen(awlen), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    resetn = 1'b0;
    inst_req = 1'b1; inst_addr = '0;
    data_req = 1'b0; data_wr = 1'b0; data_size = 2'd2;
    data_addr = '0; data_wdata = '0; data_wstrb = '0;
    arready = 1'b0; rid = '0; rdata = '0; rvalid = 1'b0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0;

    // Reset state, with inst_req held high to show accept is masked in reset
    repeat (2) @(negedge clk);
    #1;
    chk("rst_arvalid", {31'd0, arvalid}, 32'd0);
    chk("rst_rready", {31'd0, rready}, 32'd0);
    chk("rst_awvalid", {31'd0, awvalid}, 32'd0);
    chk("rst_wvalid", {31'd0, wvalid}, 32'd0);
    chk("rst_bready", {31'd0, bready}, 32'd0);
    chk("rst_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd0);
    chk("rst_araddr", araddr, 32'd0);
    chk("rst_awaddr", awaddr, 32'd0);
    @(negedge clk);
    inst_req = 1'b0;
    resetn = 1'b1;

    // 1: single instruction fetch with zero-wait slave
    @(negedge clk);
    inst_req = 1'b1; inst_addr = 32'h1c00_0000; arready = 1'b1;
    #1;
    chk("t1_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd1);
    chk("t1_data_addr_ok", {31'd0, data_addr_ok}, 32'd0);
    @(negedge clk);
    inst_req = 1'b0;
    #1;
    chk("t1_arvalid", {31'd0, arvalid}, 32'd1);
    chk("t1_arid", {28'd0, arid}, 32'd0);
    chk("t1_araddr", araddr, 32'h1c00_0000);
    chk("t1_arsize", {29'd0, arsize}, 32'd2);
    chk("t1_arlen", {24'd0, arlen}, 32'd0);
    chk("t1_arburst", {30'd0, arburst}, 32'd1);
    @(negedge clk);
    #1;
    chk("t1_rready", {31'd0, rready}, 32'd1);
    chk("t1_arvalid_drop", {31'd0, arvalid}, 32'd0);
    rvalid = 1'b1; rid = 4'd0; rdata = 32'h0280_0c06;
    #1;
    chk("t1_inst_data_ok", {31'd0, inst_data_ok}, 32'd1);
    chk("t1_inst_rdata", inst_rdata, 32'h0280_0c06);
    chk("t1_data_data_ok", {31'd0, data_data_ok}, 32'd0);
    @(negedge clk);
    rvalid = 1'b0;
    #1;
    chk("t1_inst_data_ok_pulse", {31'd0, inst_data_ok}, 32'd0);
    chk("t1_rready_drop", {31'd0, rready}, 32'd0);

    // 2: simultaneous inst and data load, data wins
    @(negedge clk);
    inst_req = 1'b1; inst_addr = 32'h1c00_0004;
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h0000_0100; data_size = 2'd2;
    #1;
    chk("t2_data_addr_ok", {31'd0, data_addr_ok}, 32'd1);
    chk("t2_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd0);
    @(negedge clk);
    data_req = 1'b0;
    #1;
    chk("t2_arid", {28'd0, arid}, 32'd1);
    chk("t2_araddr", araddr, 32'h0000_0100);
    chk("t2_inst_blocked_ar", {31'd0, inst_addr_ok}, 32'd0);
    @(negedge clk);
    #1;
    chk("t2_inst_blocked_r", {31'd0, inst_addr_ok}, 32'd0);
    rvalid = 1'b1; rid = 4'd1; rdata = 32'h1122_3344;
    #1;
    chk("t2_data_data_ok", {31'd0, data_data_ok}, 32'd1);
    chk("t2_data_rdata", data_rdata, 32'h1122_3344);
    chk("t2_inst_data_ok", {31'd0, inst_data_ok}, 32'd0);
    @(negedge clk);
    rvalid = 1'b0;
    #1;
    chk("t2_inst_addr_ok_after", {31'd0, inst_addr_ok}, 32'd1);
    @(negedge clk);
    inst_req = 1'b0;
    #1;
    chk("t2_inst_arid", {28'd0, arid}, 32'd0);
    chk("t2_inst_araddr", araddr, 32'h1c00_0004);
    @(negedge clk);
    rvalid = 1'b1; rid = 4'd0; rdata = 32'hcafe_0001;
    #1;
    chk("t2_inst_data_ok2", {31'd0, inst_data_ok}, 32'd1);
    @(negedge clk);
    rvalid = 1'b0;

    // 3+4: store with late awready, then a load to the same address held off
    @(negedge clk);
    data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h0000_0200; data_size = 2'd2;
    data_wdata = 32'hdead_beef; data_wstrb = 4'hf;
    awready = 1'b0; wready = 1'b1;
    #1;
    chk("t3_store_addr_ok", {31'd0, data_addr_ok}, 32'd1);
    chk("t3_store_no_inst", {31'd0, inst_addr_ok}, 32'd0);
    @(negedge clk);
    data_wr = 1'b0; data_wdata = '0; data_wstrb = '0;
    #1;
    chk("t3_awvalid_c1", {31'd0, awvalid}, 32'd1);
    chk("t3_wvalid_c1", {31'd0, wvalid}, 32'd1);
    chk("t3_awaddr", awaddr, 32'h0000_0200);
    chk("t3_awsize", {29'd0, awsize}, 32'd2);
    chk("t3_wdata", wdata, 32'hdead_beef);
    chk("t3_wstrb", {28'd0, wstrb}, 32'hf);
    chk("t3_wlast", {31'd0, wlast}, 32'd1);
    chk("t3_awid", {28'd0, awid}, 32'd1);
    chk("t4_load_blocked_c1", {31'd0, data_addr_ok}, 32'd0);
    @(negedge clk);
    #1;
    chk("t3_wvalid_dropped", {31'd0, wvalid}, 32'd0);
    chk("t3_awvalid_c2", {31'd0, awvalid}, 32'd1);
    chk("t4_load_blocked_c2", {31'd0, data_addr_ok}, 32'd0);
    @(negedge clk);
    awready = 1'b1;
    #1;
    chk("t3_awvalid_c3", {31'd0, awvalid}, 32'd1);
    chk("t3_bready_early", {31'd0, bready}, 32'd0);
    @(negedge clk);
    awready = 1'b0;
    #1;
    chk("t3_awvalid_dropped", {31'd0, awvalid}, 32'd0);
    chk("t3_bready", {31'd0, bready}, 32'd1);
    chk("t3_no_early_ok", {31'd0, data_data_ok}, 32'd0);
    bvalid = 1'b1;
    #1;
    chk("t3_store_data_ok", {31'd0, data_data_ok}, 32'd1);
    chk("t4_load_blocked_b", {31'd0, data_addr_ok}, 32'd0);
    @(negedge clk);
    bvalid = 1'b0;
    #1;
    chk("t3_store_ok_pulse", {31'd0, data_data_ok}, 32'd0);
    chk("t3_bready_drop", {31'd0, bready}, 32'd0);
    chk("t4_load_accept", {31'd0, data_addr_ok}, 32'd1);
    @(negedge clk);
    data_req = 1'b0;
    #1;
    chk("t4_load_arvalid", {31'd0, arvalid}, 32'd1);
    chk("t4_load_araddr", araddr, 32'h0000_0200);
    chk("t4_load_arid", {28'd0, arid}, 32'd1);
    @(negedge clk);
    rvalid = 1'b1; rid = 4'd1; rdata = 32'hdead_beef;
    #1;
    chk("t4_load_data_ok", {31'd0, data_data_ok}, 32'd1);
    chk("t4_load_rdata", data_rdata, 32'hdead_beef);
    @(negedge clk);
    rvalid = 1'b0;

    // 5: byte store, both channels ready at once
    @(negedge clk);
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'd0; data_addr = 32'h0000_0203;
    data_wdata = 32'haa00_0000; data_wstrb = 4'h8;
    awready = 1'b1; wready = 1'b1;
    #1;
    chk("t5_addr_ok", {31'd0, data_addr_ok}, 32'd1);
    @(negedge clk);
    data_req = 1'b0; data_wr = 1'b0;
    #1;
    chk("t5_awsize", {29'd0, awsize}, 32'd0);
    chk("t5_awaddr", awaddr, 32'h0000_0203);
    chk("t5_wstrb", {28'd0, wstrb}, 32'h8);
    chk("t5_wdata", wdata, 32'haa00_0000);
    @(negedge clk);
    #1;
    chk("t5_awvalid_drop", {31'd0, awvalid}, 32'd0);
    chk("t5_wvalid_drop", {31'd0, wvalid}, 32'd0);
    chk("t5_bready", {31'd0, bready}, 32'd1);
    bvalid = 1'b1;
    #1;
    chk("t5_data_ok", {31'd0, data_data_ok}, 32'd1);
    @(negedge clk);
    bvalid = 1'b0; awready = 1'b0; wready = 1'b0;

    // 6: async reset while waiting for R
    @(negedge clk);
    inst_req = 1'b1; inst_addr = 32'h1c00_0008; arready = 1'b1;
    #1;
    chk("t6_accept", {31'd0, inst_addr_ok}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2; data_wstrb = 4'hf;
    #1;
    chk("t6_in_r_r", {31'd0, rready}, 32'd1);
    chk("t6_store_blocked_by_read", {31'd0, data_addr_ok}, 32'd0);
    rid = 4'd0;
    resetn = 1'b0;
    #1;
    chk("t6_rst_rready", {31'd0, rready}, 32'd0);
    chk("t6_rst_arvalid", {31'd0, arvalid}, 32'd0);
    chk("t6_rst_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd0);
    chk("t6_rst_data_addr_ok", {31'd0, data_addr_ok}, 32'd0);
    chk("t6_rst_data_data_ok", {31'd0, data_data_ok}, 32'd0);
    chk("t6_rst_inst_data_ok", {31'd0, inst_data_ok}, 32'd0);
    @(negedge clk);
    data_req = 1'b0; data_wr = 1'b0;
    resetn = 1'b1;
    #1;
    chk("t6_idle_after_release", {31'd0, inst_addr_ok}, 32'd1);
    @(negedge clk);
    inst_req = 1'b0;
    #1;
    chk("t6_arvalid_after_release", {31'd0, arvalid}, 32'd1);
    chk("t6_araddr_after_release", araddr, 32'h1c00_0008);
    @(negedge clk);
    rvalid = 1'b1; rid = 4'd0; rdata = 32'h0000_1234;
    #1;
    chk("t6_inst_data_ok", {31'd0, inst_data_ok}, 32'd1);
    @(negedge clk);
    rvalid = 1'b0; arready = 1'b0;

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
